// File: rtl/muldiv_unit_if.sv
// Bundle of the muldiv unit's command, HI/LO write and result signals.
// The master drives operations and HI/LO writes. The slave is the unit itself.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Operations: MULT, MULTU, DIV, DIVU. The unit retires one bit per cycle.
// Signed operations run on magnitudes. Signs are applied in a final fix-up cycle.
// done/div0 are registered. They pulse in the first IDLE cycle after DONE/ZERO,
// so a new start can be accepted in that same cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE, ZERO} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;      // raw multiplicand/dividend, then its magnitude
  logic [WIDTH-1:0] b_reg;      // raw multiplier/divisor, then its magnitude
  logic             neg_a_reg;
  logic             neg_b_reg;
  logic [WIDTH-1:0] acc_reg;    // product high half / partial remainder
  logic [WIDTH-1:0] shf_reg;    // multiplier shifting into product low / dividend->quotient
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;
  logic             div0_reg;

  logic             accept;
  logic             last_bit;
  logic             is_div;
  logic             is_signed;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign accept    = (state_reg == IDLE) && bus.start;
  assign last_bit  = (count_reg == CW'(WIDTH - 1));
  assign is_div    = op_reg[1];
  assign is_signed = ~op_reg[0];

  assign bus.busy = (state_reg == PREP) || (state_reg == RUN) ||
                    (state_reg == FIX)  || (state_reg == ZERO);
  assign bus.done = done_reg;
  assign bus.div0 = div0_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A zero divisor skips the datapath entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.op[1] && (bus.b == '0)) begin
            state_next = ZERO;
          end else begin
            state_next = PREP;
          end
        end
      end
      PREP:    state_next = RUN;
      RUN:     if (last_bit) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      ZERO:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arithmetic for one iteration, magnitude forming, and final sign fix-up.
  always_comb begin
    a_mag = (is_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    b_mag = (is_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;

    // Shift-add: add the multiplicand when the current multiplier bit is set.
    mul_sum = {1'b0, acc_reg} + (shf_reg[0] ? {1'b0, a_reg} : '0);

    // Restoring division: bring in the next dividend bit, then trial-subtract.
    // Because the remainder is always below the divisor, the borrow bit alone
    // decides the quotient bit.
    div_shift = {acc_reg, shf_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    div_ge    = ~div_diff[WIDTH];

    prod = {acc_reg, shf_reg};
    if (neg_a_reg ^ neg_b_reg) begin
      prod = -prod;
    end

    // Quotient truncates toward zero. The remainder follows the dividend's sign.
    // The most-negative / -1 case wraps naturally here.
    quot = shf_reg;
    if (neg_a_reg ^ neg_b_reg) begin
      quot = -quot;
    end
    rem = acc_reg;
    if (neg_a_reg) begin
      rem = -rem;
    end

    fix_hi = is_div ? rem  : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? quot : prod[WIDTH-1:0];
  end

  // Operand capture, magnitude preparation and the per-bit iteration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      acc_reg   <= '0;
      shf_reg   <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg    <= bus.op;
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            neg_a_reg <= 1'b0;
            neg_b_reg <= 1'b0;
          end
        end
        PREP: begin
          a_reg     <= a_mag;
          b_reg     <= b_mag;
          neg_a_reg <= is_signed && a_reg[WIDTH-1];
          neg_b_reg <= is_signed && b_reg[WIDTH-1];
          acc_reg   <= '0;
          shf_reg   <= is_div ? a_mag : b_mag;
          count_reg <= '0;
        end
        RUN: begin
          if (is_div) begin
            acc_reg <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            shf_reg <= {shf_reg[WIDTH-2:0], div_ge};
          end else begin
            acc_reg <= mul_sum[WIDTH:1];
            shf_reg <= {mul_sum[0], shf_reg[WIDTH-1:1]};
          end
          count_reg <= last_bit ? '0 : count_reg + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO: software writes while idle; the result is committed in FIX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (bus.hi_we) hi_reg <= bus.wdata;
      if (bus.lo_we) lo_reg <= bus.wdata;
    end else if (state_reg == FIX) begin
      hi_reg <= fix_hi;
      lo_reg <= fix_lo;
    end
  end

  // Completion pulses: registered one cycle behind the DONE/ZERO state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_reg <= 1'b0;
      div0_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == DONE) || (state_reg == ZERO);
      div0_reg <= (state_reg == ZERO);
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit. It drives a 32-bit and an 8-bit instance.
// An arithmetic reference model with cycle-count bookkeeping predicts the outputs.
// Those predictions are compared on every negative clock edge.
// Directed literal expectations pin the model itself.
module tb_muldiv_unit;
  logic clk;
  logic rst;

  logic [1:0]       start_v, hiwe_v, lowe_v;
  logic [1:0][1:0]  op_v;
  logic [1:0][31:0] a_v, b_v, wd_v;
  logic [1:0]       busy_v, done_v, div0_v;
  logic [1:0][31:0] hi_v, lo_v;

  int total = 0;
  int bad   = 0;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clock(clk), .reset(rst), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clock(clk), .reset(rst), .bus(bus8));

  assign bus32.start = start_v[0];
  assign bus32.op    = op_v[0];
  assign bus32.a     = a_v[0];
  assign bus32.b     = b_v[0];
  assign bus32.hi_we = hiwe_v[0];
  assign bus32.lo_we = lowe_v[0];
  assign bus32.wdata = wd_v[0];
  assign busy_v[0]   = bus32.busy;
  assign done_v[0]   = bus32.done;
  assign div0_v[0]   = bus32.div0;
  assign hi_v[0]     = bus32.hi;
  assign lo_v[0]     = bus32.lo;

  assign bus8.start = start_v[1];
  assign bus8.op    = op_v[1];
  assign bus8.a     = a_v[1][7:0];
  assign bus8.b     = b_v[1][7:0];
  assign bus8.hi_we = hiwe_v[1];
  assign bus8.lo_we = lowe_v[1];
  assign bus8.wdata = wd_v[1][7:0];
  assign busy_v[1]  = bus8.busy;
  assign done_v[1]  = bus8.done;
  assign div0_v[1]  = bus8.div0;
  assign hi_v[1]    = {24'd0, bus8.hi};
  assign lo_v[1]    = {24'd0, bus8.lo};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wdt(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] msk(input int d);
    logic [63:0] m;
    m = (64'd1 << wdt(d)) - 64'd1;
    return m[31:0];
  endfunction

  // Reference arithmetic: returns {hi, lo} for a w-bit operation.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    logic [63:0] mask, ua, ub, p, hi, lo;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = (p >> w) & mask; lo = p & mask; end
      2'b01: begin p = ua * ub;      hi = (p >> w) & mask; lo = p & mask; end
      2'b10: begin q = sa / sb; r = sa % sb; hi = 64'(r) & mask; lo = 64'(q) & mask; end
      default: begin hi = ua % ub; lo = ua / ub; end
    endcase
    return {hi[31:0], lo[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state. It holds edge numbers of accept, commit, done and next-idle.
  int          cyc = 0;
  bit          model_ready = 1'b0;
  int          m_acc[2], m_busy_last[2], m_commit[2], m_done[2], m_idle_edge[2];
  logic        m_div0[2];
  logic [31:0] m_hi[2], m_lo[2], m_rhi[2], m_rlo[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_ready = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_hi[d] = '0; m_lo[d] = '0; m_rhi[d] = '0; m_rlo[d] = '0;
        m_acc[d] = -100; m_busy_last[d] = -100; m_commit[d] = -100;
        m_done[d] = -100; m_idle_edge[d] = 0; m_div0[d] = 1'b0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (cyc == m_commit[d]) begin
          m_hi[d] = m_rhi[d];
          m_lo[d] = m_rlo[d];
        end
        if (cyc >= m_idle_edge[d]) begin
          if (hiwe_v[d]) m_hi[d] = wd_v[d] & msk(d);
          if (lowe_v[d]) m_lo[d] = wd_v[d] & msk(d);
          if (start_v[d]) begin
            m_acc[d] = cyc;
            if (op_v[d][1] && ((b_v[d] & msk(d)) == 32'd0)) begin
              m_div0[d] = 1'b1;
              m_commit[d] = -100;
              m_done[d] = cyc + 1;
              m_busy_last[d] = cyc;
              m_idle_edge[d] = cyc + 2;
            end else begin
              m_div0[d] = 1'b0;
              {m_rhi[d], m_rlo[d]} = ref_res(op_v[d], a_v[d], b_v[d], wdt(d));
              m_commit[d] = cyc + wdt(d) + 2;
              m_done[d] = cyc + wdt(d) + 3;
              m_busy_last[d] = cyc + wdt(d) + 1;
              m_idle_edge[d] = cyc + wdt(d) + 4;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy[%0d]", d), 64'(busy_v[d]),
            64'((cyc >= m_acc[d]) && (cyc <= m_busy_last[d])));
        chk($sformatf("done[%0d]", d), 64'(done_v[d]), 64'(cyc == m_done[d]));
        chk($sformatf("div0[%0d]", d), 64'(div0_v[d]), 64'((cyc == m_done[d]) && m_div0[d]));
        chk($sformatf("hi[%0d]", d), 64'(hi_v[d]), 64'(m_hi[d]));
        chk($sformatf("lo[%0d]", d), 64'(lo_v[d]), 64'(m_lo[d]));
      end
    end
  end

  // Issue one operation and measure the edges from accept to the done pulse.
  task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic hw, input logic [31:0] wd,
                        output int lat);
    @(posedge clk); #1;
    start_v[d] = 1'b1; op_v[d] = op; a_v[d] = a; b_v[d] = b;
    hiwe_v[d] = hw; wd_v[d] = wd;
    @(posedge clk); #1;
    start_v[d] = 1'b0; hiwe_v[d] = 1'b0;
    op_v[d] = 2'($urandom_range(0, 3)); a_v[d] = $urandom; b_v[d] = $urandom;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_v[d]) begin
        lat = i;
        break;
      end
    end
    chk($sformatf("done_seen[%0d]", d), 64'(lat >= 0), 64'd1);
    $display("dut%0d op=%0d a=%h b=%h -> hi=%h lo=%h div0=%0d latency=%0d",
             wdt(d), op, a, b, hi_v[d], lo_v[d], div0_v[d], lat);
  endtask

  task automatic write_hl(input int d, input logic hw, input logic lw, input logic [31:0] wd);
    @(posedge clk); #1;
    hiwe_v[d] = hw; lowe_v[d] = lw; wd_v[d] = wd;
    @(posedge clk); #1;
    hiwe_v[d] = 1'b0; lowe_v[d] = 1'b0;
  endtask

  task automatic count_done(input int d, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_v[d]) pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    rst = 1'b1;
    start_v = '0; hiwe_v = '0; lowe_v = '0;
    op_v = '0; a_v = '0; b_v = '0; wd_v = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", 64'(hi_v[0]), 64'd0);
    chk("reset_lo", 64'(lo_v[0]), 64'd0);
    chk("reset_busy", 64'(busy_v[0]), 64'd0);

    // 32-bit directed operations
    run_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, lat);
    chk("t1_hi", 64'(hi_v[0]), 64'hFFFFFFFE);
    chk("t1_lo", 64'(lo_v[0]), 64'h00000001);
    chk("t1_latency", 64'(lat), 64'd35);
    run_op(0, 2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 32'd0, lat);
    chk("t2_hi", 64'(hi_v[0]), 64'hFFFFFFFF);
    chk("t2_lo", 64'(lo_v[0]), 64'hFFFFFFEB);
    run_op(0, 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0, lat);
    chk("t3_lo", 64'(lo_v[0]), 64'hFFFFFFFD);
    chk("t3_hi", 64'(hi_v[0]), 64'hFFFFFFFF);
    run_op(0, 2'b11, 32'd7, 32'd2, 1'b0, 32'd0, lat);
    chk("t4_lo", 64'(lo_v[0]), 64'd3);
    chk("t4_hi", 64'(hi_v[0]), 64'd1);
    run_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, lat);
    chk("t5_lo", 64'(lo_v[0]), 64'h80000000);
    chk("t5_hi", 64'(hi_v[0]), 64'd0);
    chk("t5_div0", 64'(div0_v[0]), 64'd0);
    run_op(0, 2'b10, 32'd100, 32'hFFFFFFF9, 1'b0, 32'd0, lat);
    chk("div_neg_divisor_lo", 64'(lo_v[0]), 64'hFFFFFFF2);
    chk("div_neg_divisor_hi", 64'(hi_v[0]), 64'd2);

    // Divide by zero. LO is preloaded first. HI is written in the same cycle as start.
    write_hl(0, 1'b0, 1'b1, 32'h22);
    run_op(0, 2'b10, 32'd55, 32'd0, 1'b1, 32'h11, lat);
    chk("t6_latency", 64'(lat), 64'd1);
    chk("t6_div0", 64'(div0_v[0]), 64'd1);
    chk("t6_hi", 64'(hi_v[0]), 64'h11);
    chk("t6_lo", 64'(lo_v[0]), 64'h22);

    // A second start while busy is dropped.
    @(posedge clk); #1;
    start_v[0] = 1'b1; op_v[0] = 2'b01; a_v[0] = 32'h12345678; b_v[0] = 32'h10;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 start_v[0] = 1'b1; op_v[0] = 2'b00; a_v[0] = 32'd5; b_v[0] = 32'd5;
    @(posedge clk); #1 start_v[0] = 1'b0;
    count_done(0, 45, pulses);
    chk("t7_pulses", 64'(pulses), 64'd1);
    chk("t7_hi", 64'(hi_v[0]), 64'd1);
    chk("t7_lo", 64'(lo_v[0]), 64'h23456780);
    $display("dut32 start-while-busy: done pulses=%0d hi=%h lo=%h", pulses, hi_v[0], lo_v[0]);

    // Reset while RUN holds count 10.
    @(posedge clk); #1;
    start_v[0] = 1'b1; op_v[0] = 2'b01; a_v[0] = 32'd3; b_v[0] = 32'd4;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t8_busy", 64'(busy_v[0]), 64'd0);
    chk("t8_hi", 64'(hi_v[0]), 64'd0);
    chk("t8_lo", 64'(lo_v[0]), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    count_done(0, 45, pulses);
    chk("t8_no_done", 64'(pulses), 64'd0);
    $display("dut32 reset mid-run: done pulses after reset=%0d", pulses);

    // 8-bit instance
    run_op(1, 2'b01, 32'hFF, 32'hFF, 1'b0, 32'd0, lat);
    chk("t9_multu_hi", 64'(hi_v[1]), 64'hFE);
    chk("t9_multu_lo", 64'(lo_v[1]), 64'h01);
    chk("t9_latency", 64'(lat), 64'd11);
    run_op(1, 2'b00, 32'hFD, 32'd7, 1'b0, 32'd0, lat);
    chk("t9_mult_hi", 64'(hi_v[1]), 64'hFF);
    chk("t9_mult_lo", 64'(lo_v[1]), 64'hEB);
    run_op(1, 2'b10, 32'hF9, 32'd2, 1'b0, 32'd0, lat);
    chk("t9_div_lo", 64'(lo_v[1]), 64'hFD);
    chk("t9_div_hi", 64'(hi_v[1]), 64'hFF);
    run_op(1, 2'b11, 32'd7, 32'd2, 1'b0, 32'd0, lat);
    chk("t9_divu_lo", 64'(lo_v[1]), 64'd3);
    chk("t9_divu_hi", 64'(hi_v[1]), 64'd1);
    chk("t9_divu_latency", 64'(lat), 64'd11);
    run_op(1, 2'b10, 32'h80, 32'hFF, 1'b0, 32'd0, lat);
    chk("t9_ovf_lo", 64'(lo_v[1]), 64'h80);
    chk("t9_ovf_hi", 64'(hi_v[1]), 64'd0);
    run_op(1, 2'b11, 32'hFF, 32'd3, 1'b0, 32'd0, lat);
    chk("t9_divu_ff_lo", 64'(lo_v[1]), 64'h55);
    run_op(1, 2'b00, 32'h80, 32'h80, 1'b0, 32'd0, lat);
    chk("t9_mult_minmin_hi", 64'(hi_v[1]), 64'h40);
    chk("t9_mult_minmin_lo", 64'(lo_v[1]), 64'h00);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
